// File: rtl/apes_dac_pkg.sv
// rtl/apes_dac_pkg.sv - shared constants, state encoding and round-robin helper for the DAC arbiter
package apes_dac_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_SHIFT = 2'd2
    } dac_state_e;

    localparam logic [8:0]  DAC_ADDR_DEF  = 9'h008;
    localparam logic [11:0] INIT_CODE_DEF = 12'h4D9;
    localparam int          FRAME_W       = 16;
    localparam int          GUARD_BITS    = 1;

    // First pending channel strictly after 'last', wrapping at n; returns 'last' if none pending.
    function automatic logic [3:0] rr_next(input logic [15:0] pend, input logic [3:0] last,
                                           input int n);
        logic [3:0] pick;
        logic       found;
        int         idx;
        pick  = last;
        found = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            idx = (int'(last) + k) % n;
            if (k <= n && !found && pend[4'(idx)]) begin
                pick  = 4'(idx);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/apes_dac_shifter.sv
// rtl/apes_dac_shifter.sv - serialises one 16-bit DAC frame with chip select, guard period and done pulse
module apes_dac_shifter
    import apes_dac_pkg::*;
#(
    parameter int NCH       = 4,
    parameter int HALF_LOG2 = 5
) (
    input  logic               clk50,
    input  logic               rst_n,
    input  logic               start_i,
    input  logic [FRAME_W-1:0] frame_i,
    input  logic [3:0]         ch_i,
    output logic               done_o,
    output logic               dac_clk_o,
    output logic               dac_dat_o,
    output logic [NCH-1:0]     cs_n_o
);

    localparam int              BIT_CYC   = 2 ** (HALF_LOG2 + 1);
    localparam int              CW        = HALF_LOG2 + 6;
    localparam logic [CW-1:0]   FRAME_CYC = CW'(FRAME_W * BIT_CYC);
    localparam logic [CW-1:0]   LAST_CYC  = CW'((FRAME_W + GUARD_BITS) * BIT_CYC - 1);

    logic               active_q;
    logic               done_q;
    logic [CW-1:0]      cyc_q;
    logic [FRAME_W-1:0] shreg_q;
    logic [3:0]         ch_q;
    logic               in_frame;
    logic               bit_end;

    // Cycles past FRAME_CYC are the guard: bus idle, chip selects released.
    assign in_frame = active_q && (cyc_q < FRAME_CYC);
    assign bit_end  = &cyc_q[HALF_LOG2:0];

    always_ff @(posedge clk50 or negedge rst_n) begin
        if (!rst_n) begin
            active_q <= 1'b0;
            done_q   <= 1'b0;
            cyc_q    <= '0;
            shreg_q  <= '0;
            ch_q     <= '0;
        end else begin
            done_q <= 1'b0;
            if (!active_q) begin
                if (start_i) begin
                    active_q <= 1'b1;
                    cyc_q    <= '0;
                    shreg_q  <= frame_i;
                    ch_q     <= ch_i;
                end
            end else if (cyc_q == LAST_CYC) begin
                active_q <= 1'b0;
                done_q   <= 1'b1;
                cyc_q    <= '0;
                shreg_q  <= '0;
            end else begin
                cyc_q <= cyc_q + CW'(1);
                if (in_frame && bit_end) begin
                    shreg_q <= {shreg_q[FRAME_W-2:0], 1'b0};
                end
            end
        end
    end

    assign done_o    = done_q;
    assign dac_clk_o = in_frame & cyc_q[HALF_LOG2];
    assign dac_dat_o = in_frame & shreg_q[FRAME_W-1];

    always_comb begin
        cs_n_o = '1;
        for (int i = 0; i < NCH; i++) begin
            cs_n_o[i] = !(in_frame && (ch_q == 4'(i)));
        end
    end

endmodule

// File: rtl/apes_dac_arb.sv
// rtl/apes_dac_arb.sv - per-channel DAC code registers with round-robin arbitration onto one serial bus
module apes_dac_arb
    import apes_dac_pkg::*;
#(
    parameter int          NCH       = 4,
    parameter logic [8:0]  DAC_ADDR  = DAC_ADDR_DEF,
    parameter logic [11:0] INIT_CODE = INIT_CODE_DEF,
    parameter int          HALF_LOG2 = 5
) (
    input  logic           clk50,
    input  logic           rst_n,
    input  logic           dac_rst,
    input  logic           regw_pls,
    input  logic [8:0]     Lcla,
    input  logic [31:0]    Lcld,
    output logic           Dac_clk,
    output logic           Dac_dat,
    output logic [NCH-1:0] CTRL_ENn,
    output logic           dac_busy,
    output logic [31:0]    dac_stat
);

    localparam int         IW    = $clog2(NCH);
    localparam logic [4:0] NCH_W = 5'(NCH);

    dac_state_e     state_q, state_d;
    logic [11:0]    code_q [NCH];
    logic [11:0]    code_d [NCH];
    logic [NCH-1:0] pending_q, pending_d;
    logic [3:0]     last_q, last_d;
    logic [3:0]     wr_ch;
    logic [3:0]     sel;
    logic           wr_en;
    logic           start;
    logic           done;
    logic           unused_lcld;

    assign unused_lcld = ^Lcld[31:16];
    assign wr_ch       = Lcld[15:12];
    assign wr_en       = regw_pls && (Lcla == DAC_ADDR) && ({1'b0, wr_ch} < NCH_W) && !dac_rst;
    assign sel         = rr_next(16'(pending_q), last_q, NCH);
    assign dac_busy    = (state_q != ST_IDLE);

    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        case (state_q)
            ST_IDLE:  if (pending_q != '0 && !dac_rst) state_d = ST_GRANT;
            ST_GRANT: begin
                start   = 1'b1;
                state_d = ST_SHIFT;
            end
            ST_SHIFT: if (done) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Ordering gives a same-cycle write priority over the grant clear, and dac_rst over both.
    always_comb begin
        code_d    = code_q;
        pending_d = pending_q;
        last_d    = last_q;
        if (start) begin
            pending_d[sel[IW-1:0]] = 1'b0;
            last_d                 = sel;
        end
        if (wr_en) begin
            code_d[wr_ch[IW-1:0]]    = Lcld[11:0];
            pending_d[wr_ch[IW-1:0]] = 1'b1;
        end
        if (dac_rst) begin
            for (int i = 0; i < NCH; i++) begin
                code_d[i] = INIT_CODE;
            end
            pending_d = '1;
        end
    end

    always_ff @(posedge clk50 or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            pending_q <= '1;
            last_q    <= 4'(NCH - 1);
            for (int i = 0; i < NCH; i++) begin
                code_q[i] <= INIT_CODE;
            end
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            last_q    <= last_d;
            code_q    <= code_d;
        end
    end

    always_comb begin
        dac_stat     = '0;
        dac_stat[31] = dac_busy;
        for (int i = 0; i < NCH && i < 4; i++) begin
            dac_stat[24+i] = pending_q[i];
        end
        dac_stat[21:20] = last_q[1:0];
        dac_stat[11:0]  = code_q[last_q[IW-1:0]];
    end

    apes_dac_shifter #(
        .NCH       (NCH),
        .HALF_LOG2 (HALF_LOG2)
    ) u_shifter (
        .clk50     (clk50),
        .rst_n     (rst_n),
        .start_i   (start),
        .frame_i   ({4'h0, code_q[sel[IW-1:0]]}),
        .ch_i      (sel),
        .done_o    (done),
        .dac_clk_o (Dac_clk),
        .dac_dat_o (Dac_dat),
        .cs_n_o    (CTRL_ENn)
    );

endmodule

// File: tb/tb_apes_dac_arb.sv
// tb/tb_apes_dac_arb.sv - self-checking bench: bus monitor with frame scoreboard plus write vector table
module tb_apes_dac_arb;

    logic        clk50 = 1'b0;
    logic        rst_n;
    logic        dac_rst;
    logic        regw_pls;
    logic [8:0]  Lcla;
    logic [31:0] Lcld;
    logic        Dac_clk;
    logic        Dac_dat;
    logic [3:0]  CTRL_ENn;
    logic        dac_busy;
    logic [31:0] dac_stat;

    apes_dac_arb dut (
        .clk50    (clk50),
        .rst_n    (rst_n),
        .dac_rst  (dac_rst),
        .regw_pls (regw_pls),
        .Lcla     (Lcla),
        .Lcld     (Lcld),
        .Dac_clk  (Dac_clk),
        .Dac_dat  (Dac_dat),
        .CTRL_ENn (CTRL_ENn),
        .dac_busy (dac_busy),
        .dac_stat (dac_stat)
    );

    always #10 clk50 = ~clk50;

    typedef struct {
        logic [3:0]  ch;
        logic [15:0] dat;
    } frm_t;

    typedef struct {
        logic [8:0]  addr;
        logic [31:0] data;
        logic        frm;
        logic [3:0]  ch;
        logic [15:0] dat;
        logic [31:0] stat;
    } vec_t;

    frm_t sb[$];
    vec_t vecs[7];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   overlap_n = 0;
    int   idle_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk50) cyc <= cyc + 1;

    // Bus monitor: rebuilds frames from the serial lines and retires them against the scoreboard.
    logic        prev_clk, prev_busy, in_cs, cs_bad;
    logic [3:0]  cs_pat, fch;
    logic [15:0] shv;
    int          t_busy, t_cs, nbits;
    frm_t        e;

    always @(negedge clk50) begin
        if (!rst_n) begin
            prev_clk  = 1'b0;
            prev_busy = 1'b0;
            in_cs     = 1'b0;
            nbits     = 0;
            t_busy    = -100;
        end else begin
            if (dac_busy && !prev_busy) t_busy = cyc;
            if (!dac_busy && prev_busy) check("busy_len", cyc - t_busy, 1090);
            if ($countones(~CTRL_ENn) > 1) overlap_n++;
            if (!dac_busy && (Dac_clk || Dac_dat || CTRL_ENn != 4'hF)) idle_bad++;
            if (!in_cs && CTRL_ENn != 4'hF) begin
                in_cs  = 1'b1;
                t_cs   = cyc;
                cs_pat = CTRL_ENn;
                cs_bad = 1'b0;
                nbits  = 0;
                fch    = 4'hF;
                for (int i = 3; i >= 0; i--) if (!CTRL_ENn[i]) fch = 4'(i);
                check("cs_delay", cyc - t_busy, 1);
            end
            if (in_cs && CTRL_ENn != 4'hF && CTRL_ENn != cs_pat) cs_bad = 1'b1;
            if (Dac_clk && !prev_clk) begin
                shv   = {shv[14:0], Dac_dat};
                nbits = nbits + 1;
            end
            if (in_cs && CTRL_ENn == 4'hF) begin
                in_cs = 1'b0;
                check("cs_len", cyc - t_cs, 1024);
                check("nbits", nbits, 16);
                check("cs_stable", cs_bad, 1'b0);
                check("frame_expected", sb.size() != 0, 1'b1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check("frame_ch", fch, e.ch);
                    check("frame_dat", shv, e.dat);
                end
            end
            prev_clk  = Dac_clk;
            prev_busy = dac_busy;
        end
    end

    task automatic bus_write(input logic [8:0] a, input logic [31:0] d);
        @(negedge clk50);
        Lcla     = a;
        Lcld     = d;
        regw_pls = 1'b1;
        @(negedge clk50);
        regw_pls = 1'b0;
    endtask

    task automatic expect_frame(input logic [3:0] ch, input logic [15:0] dat);
        frm_t f;
        f.ch  = ch;
        f.dat = dat;
        sb.push_back(f);
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (n < budget && !(sb.size() == 0 && !dac_busy && dac_stat[27:24] == 4'h0)) begin
            @(negedge clk50);
            n++;
        end
        check("drain_timeout", n >= budget, 1'b0);
        repeat (3) @(negedge clk50);
    endtask

    task automatic wait_busy(input logic lvl, input int budget);
        int n = 0;
        @(negedge clk50);
        while (n < budget && dac_busy !== lvl) begin
            @(negedge clk50);
            n++;
        end
        check("busy_timeout", n >= budget, 1'b0);
    endtask

    task automatic wait_cs(input int ch, input int budget);
        int n = 0;
        while (n < budget && CTRL_ENn[ch] !== 1'b0) begin
            @(negedge clk50);
            n++;
        end
        check("cs_timeout", n >= budget, 1'b0);
    endtask

    initial begin
        #(20 * 100000);
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{9'h008, 32'h0000_2ABC, 1'b1, 4'd2, 16'h0ABC, 32'h0020_0ABC};
        vecs[1] = '{9'h008, 32'h0000_0123, 1'b1, 4'd0, 16'h0123, 32'h0000_0123};
        vecs[2] = '{9'h008, 32'hFFFF_3FFF, 1'b1, 4'd3, 16'h0FFF, 32'h0030_0FFF};
        vecs[3] = '{9'h008, 32'h0000_5777, 1'b0, 4'd0, 16'h0000, 32'h0030_0FFF};
        vecs[4] = '{9'h009, 32'h0000_1555, 1'b0, 4'd0, 16'h0000, 32'h0030_0FFF};
        vecs[5] = '{9'h008, 32'h0000_1000, 1'b1, 4'd1, 16'h0000, 32'h0010_0000};
        vecs[6] = '{9'h008, 32'h0000_F123, 1'b0, 4'd0, 16'h0000, 32'h0010_0000};

        rst_n    = 1'b0;
        dac_rst  = 1'b0;
        regw_pls = 1'b0;
        Lcla     = '0;
        Lcld     = '0;
        repeat (3) @(negedge clk50);
        check("rst_dac_clk", Dac_clk, 1'b0);
        check("rst_dac_dat", Dac_dat, 1'b0);
        check("rst_cs", CTRL_ENn, 4'hF);
        check("rst_busy", dac_busy, 1'b0);
        check("rst_stat", dac_stat, 32'h0F30_04D9);

        // Power-up: every channel gets INIT_CODE, starting at channel 0.
        for (int c = 0; c < 4; c++) expect_frame(4'(c), 16'h04D9);
        rst_n = 1'b1;
        wait_drain(6000);
        check("init_stat", dac_stat, 32'h0030_04D9);

        for (int i = 0; i < 7; i++) begin
            if (vecs[i].frm) expect_frame(vecs[i].ch, vecs[i].dat);
            bus_write(vecs[i].addr, vecs[i].data);
            repeat (10) @(negedge clk50);
            check($sformatf("vec%0d_busy", i), dac_busy, vecs[i].frm);
            wait_drain(3000);
            check($sformatf("vec%0d_stat", i), dac_stat, vecs[i].stat);
        end

        // Write landing in the same cycle as the grant that clears it keeps the channel pending.
        expect_frame(4'd0, 16'h0100);
        expect_frame(4'd1, 16'h0101);
        expect_frame(4'd1, 16'h0999);
        bus_write(9'h008, 32'h0000_0100);
        wait_busy(1'b1, 50);
        bus_write(9'h008, 32'h0000_1101);
        wait_busy(1'b0, 1500);
        bus_write(9'h008, 32'h0000_1999);
        wait_drain(4000);
        check("grant_race_stat", dac_stat, 32'h0010_0999);

        // Rewrites during a frame collapse into one follow-up frame with the last code.
        expect_frame(4'd1, 16'h0333);
        expect_frame(4'd1, 16'h0222);
        bus_write(9'h008, 32'h0000_1333);
        wait_cs(1, 100);
        bus_write(9'h008, 32'h0000_1111);
        bus_write(9'h008, 32'h0000_1222);
        wait_drain(4000);
        check("collapse_stat", dac_stat, 32'h0010_0222);

        // Round-robin after ch2: ch3 beats ch0.
        expect_frame(4'd2, 16'h00AA);
        expect_frame(4'd3, 16'h00D3);
        expect_frame(4'd0, 16'h00C0);
        bus_write(9'h008, 32'h0000_20AA);
        wait_busy(1'b1, 50);
        bus_write(9'h008, 32'h0000_00C0);
        bus_write(9'h008, 32'h0000_30D3);
        wait_drain(5000);
        check("rr_stat", dac_stat, 32'h0000_00C0);

        // dac_rst mid-frame: frame finishes, then all channels re-init from after ch1.
        expect_frame(4'd1, 16'h0456);
        bus_write(9'h008, 32'h0000_1456);
        wait_cs(1, 100);
        repeat (100) @(negedge clk50);
        dac_rst = 1'b1;
        bus_write(9'h008, 32'h0000_2777);
        wait_busy(1'b0, 1500);
        repeat (50) @(negedge clk50);
        check("dac_rst_hold_busy", dac_busy, 1'b0);
        check("dac_rst_hold_stat", dac_stat, 32'h0F10_04D9);
        expect_frame(4'd2, 16'h04D9);
        expect_frame(4'd3, 16'h04D9);
        expect_frame(4'd0, 16'h04D9);
        expect_frame(4'd1, 16'h04D9);
        @(negedge clk50);
        dac_rst = 1'b0;
        wait_drain(6000);
        check("dac_rst_stat", dac_stat, 32'h0010_04D9);

        // rst_n mid-frame aborts at once.
        bus_write(9'h008, 32'h0000_3321);
        wait_cs(3, 100);
        repeat (200) @(negedge clk50);
        rst_n = 1'b0;
        #1;
        check("abort_cs", CTRL_ENn, 4'hF);
        check("abort_dac_clk", Dac_clk, 1'b0);
        check("abort_busy", dac_busy, 1'b0);
        check("abort_stat", dac_stat, 32'h0F30_04D9);
        sb.delete();
        repeat (3) @(negedge clk50);
        for (int c = 0; c < 4; c++) expect_frame(4'(c), 16'h04D9);
        rst_n = 1'b1;
        wait_drain(6000);
        check("abort_reinit_stat", dac_stat, 32'h0030_04D9);

        check("cs_overlap", overlap_n, 0);
        check("idle_bus", idle_bad, 0);
        check("sb_empty", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
